sdram_mport_arb: RTL

SDRAM_MPORT_ARB -- requirements
Module: sdram_mport_arb

---
 rtl/sdram_mport_arb.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_mport_arb.sv
// ---------------------------------------------------------------------------
// sdram_mport_arb
// Round-robin arbiter that lets CH burst channels (frame-buffer FIFOs) share
// one SDRAM controller. Each channel walks through its own frame region
// (ch_base .. ch_max) burst by burst. With PINGPONG enabled, the top address
// bit selects one of two half-memory buffers, and that bit flips every frame.
//
// Ports
//   clk_ref, rst_n          : single clock, asynchronous active-low reset
//   sdram_init_done         : controller ready; no new grant while low
//   ch_req/ch_dir/ch_len    : per-channel request, direction (1=read), burst length
//   ch_base/ch_max          : per-channel frame start / end (exclusive) address
//   ch_load                 : per-channel pulse that rewinds offset and bank
//   ch_grant                : one-hot, high from request issue until ack falls
//   ch_frame_done           : one-cycle pulse per completed frame
//   ch_bank                 : current ping-pong half per channel
//   sdram_wr_req/rd_req     : requests to the controller
//   sdram_wr_ack/rd_ack     : controller acks, high during data transfer
//   sys_wraddr/sys_rdaddr   : burst start address
//   sdwr_byte/sdrd_byte     : burst length of the granted channel
// ---------------------------------------------------------------------------
module sdram_mport_arb #(
    parameter int CH       = 4,
    parameter int AW       = 22,
    parameter int LW       = 9,
    parameter int PINGPONG = 1
) (
    input  logic             clk_ref,
    input  logic             rst_n,
    input  logic             sdram_init_done,
    input  logic [CH-1:0]    ch_req,
    input  logic [CH-1:0]    ch_dir,
    input  logic [CH*LW-1:0] ch_len,
    input  logic [CH*AW-1:0] ch_base,
    input  logic [CH*AW-1:0] ch_max,
    input  logic [CH-1:0]    ch_load,
    output logic [CH-1:0]    ch_grant,
    output logic [CH-1:0]    ch_frame_done,
    output logic [CH-1:0]    ch_bank,
    output logic             sdram_wr_req,
    output logic             sdram_rd_req,
    input  logic             sdram_wr_ack,
    input  logic             sdram_rd_ack,
    output logic [AW-1:0]    sys_wraddr,
    output logic [AW-1:0]    sys_rdaddr,
    output logic [LW-1:0]    sdwr_byte,
    output logic [LW-1:0]    sdrd_byte
);

    localparam int PW = $clog2(CH);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_XFER, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   cur_q, cur_d;
    logic            dir_q, dir_d;
    logic [LW-1:0]   len_q, len_d;
    logic [AW-1:0]   offset_q [CH];
    logic [AW-1:0]   offset_d [CH];
    logic [CH-1:0]   bank_q, bank_d;
    logic [CH-1:0]   load_pend_q, load_pend_d;
    logic [CH-1:0]   grant_q, grant_d;
    logic [CH-1:0]   frame_done_q, frame_done_d;
    logic            wr_req_q, wr_req_d;
    logic            rd_req_q, rd_req_d;
    logic [AW-1:0]   wraddr_q, wraddr_d;
    logic [AW-1:0]   rdaddr_q, rdaddr_d;
    logic [LW-1:0]   wrbyte_q, wrbyte_d;
    logic [LW-1:0]   rdbyte_q, rdbyte_d;

    logic [CH-1:0]   eligible;
    logic            found;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   cand;
    logic [LW-1:0]   sel_len;
    logic [AW-1:0]   sel_addr;
    logic [AW:0]     span;
    logic [AW:0]     next_off;
    logic            wrap;
    logic            sel_ack;

    // A zero-length request would never make progress, so it is not eligible.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            eligible[i] = ch_req[i] && (ch_len[i*LW +: LW] != '0);
        end
    end

    // Round-robin search starting at ptr_q (the channel after the last grant).
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < CH; k++) begin
            cand = PW'((int'(ptr_q) + k) % CH);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Issue address of the candidate; with ping-pong the MSB is the bank bit.
    always_comb begin
        sel_len  = ch_len[int'(sel)*LW +: LW];
        sel_addr = ch_base[int'(sel)*AW +: AW] + offset_q[sel];
        if (PINGPONG != 0) begin
            sel_addr[AW-1] = bank_q[sel];
        end
    end

    // Frame-end test for the active channel, one extra bit so the sum cannot wrap.
    always_comb begin
        span     = {1'b0, ch_max[int'(cur_q)*AW +: AW] - ch_base[int'(cur_q)*AW +: AW]};
        next_off = {1'b0, offset_q[cur_q]} + {{(AW+1-LW){1'b0}}, len_q};
        wrap     = (next_off >= span);
        sel_ack  = dir_q ? sdram_rd_ack : sdram_wr_ack;
    end

    // Next-state logic. A load for the channel currently owning the bus is
    // deferred to DONE so the in-flight burst's address stays consistent.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cur_d        = cur_q;
        dir_d        = dir_q;
        len_d        = len_q;
        offset_d     = offset_q;
        bank_d       = bank_q;
        load_pend_d  = load_pend_q;
        grant_d      = grant_q;
        frame_done_d = '0;
        wr_req_d     = wr_req_q;
        rd_req_d     = rd_req_q;
        wraddr_d     = wraddr_q;
        rdaddr_d     = rdaddr_q;
        wrbyte_d     = wrbyte_q;
        rdbyte_d     = rdbyte_q;

        for (int i = 0; i < CH; i++) begin
            if (ch_load[i]) begin
                if ((state_q == S_ARB && found && sdram_init_done && int'(sel) == i) ||
                    ((state_q == S_REQ || state_q == S_XFER || state_q == S_DONE) &&
                     int'(cur_q) == i)) begin
                    load_pend_d[i] = 1'b1;
                end else begin
                    offset_d[i] = '0;
                    bank_d[i]   = 1'b0;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (sdram_init_done && (|eligible)) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (sdram_init_done && found) begin
                    cur_d        = sel;
                    ptr_d        = PW'((int'(sel) + 1) % CH);
                    dir_d        = ch_dir[sel];
                    len_d        = sel_len;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    if (ch_dir[sel]) begin
                        rd_req_d = 1'b1;
                        rdaddr_d = sel_addr;
                        rdbyte_d = sel_len;
                    end else begin
                        wr_req_d = 1'b1;
                        wraddr_d = sel_addr;
                        wrbyte_d = sel_len;
                    end
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (sel_ack) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    state_d  = S_XFER;
                end
            end
            S_XFER: begin
                if (!sel_ack) begin
                    grant_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (load_pend_q[cur_q] || ch_load[cur_q]) begin
                    offset_d[cur_q]    = '0;
                    bank_d[cur_q]      = 1'b0;
                    load_pend_d[cur_q] = 1'b0;
                end else if (wrap) begin
                    offset_d[cur_q]     = '0;
                    frame_done_d[cur_q] = 1'b1;
                    if (PINGPONG != 0) begin
                        bank_d[cur_q] = ~bank_q[cur_q];
                    end
                end else begin
                    offset_d[cur_q] = next_off[AW-1:0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cur_q        <= '0;
            dir_q        <= 1'b0;
            len_q        <= '0;
            for (int i = 0; i < CH; i++) begin
                offset_q[i] <= '0;
            end
            bank_q       <= '0;
            load_pend_q  <= '0;
            grant_q      <= '0;
            frame_done_q <= '0;
            wr_req_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            wraddr_q     <= '0;
            rdaddr_q     <= '0;
            wrbyte_q     <= '0;
            rdbyte_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cur_q        <= cur_d;
            dir_q        <= dir_d;
            len_q        <= len_d;
            offset_q     <= offset_d;
            bank_q       <= bank_d;
            load_pend_q  <= load_pend_d;
            grant_q      <= grant_d;
            frame_done_q <= frame_done_d;
            wr_req_q     <= wr_req_d;
            rd_req_q     <= rd_req_d;
            wraddr_q     <= wraddr_d;
            rdaddr_q     <= rdaddr_d;
            wrbyte_q     <= wrbyte_d;
            rdbyte_q     <= rdbyte_d;
        end
    end

    assign ch_grant      = grant_q;
    assign ch_frame_done = frame_done_q;
    assign ch_bank       = bank_q;
    assign sdram_wr_req  = wr_req_q;
    assign sdram_rd_req  = rd_req_q;
    assign sys_wraddr    = wraddr_q;
    assign sys_rdaddr    = rdaddr_q;
    assign sdwr_byte     = wrbyte_q;
    assign sdrd_byte     = rdbyte_q;

endmodule
